regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data word width in bits; legal values are 16 or greater.
REQ-002 Parameter NREG, default 32, register count; legal values are powers of two and 2 or greater.
REQ-003 Parameter AW, default $clog2(NREG), register address width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 we  in  3  write mode: 001 zero-extend byte, 010 sign-extend byte, 011 zero-extend half, 100 sign-extend half, 101 full word, other values no write.
REQ-007 wa  in  AW  write address.
REQ-008 wd  in  XLEN  write data.
REQ-009 ra1, ra2  in  AW each  read addresses.
REQ-010 rd1, rd2  out  XLEN each  read data.
REQ-011 iss_v  in  1  issue strobe; marks register iss_rd as pending a writeback.
REQ-012 iss_rd  in  AW  destination of the issued operation.
REQ-013 busy1, busy2  out  1 each  the operand at ra1 / ra2 has a pending write that is not resolved this cycle.
REQ-014 iss_stall  out  1  iss_rd already has a pending write (WAW hazard).

Function
REQ-015 Register 0 SHALL read as 0 at all times; writes to it and issues to it SHALL be ignored.
REQ-016 The write value SHALL be ext(we, wd): bits [7:0] or [15:0] extended to XLEN with zeros or with the sign bit, or wd unchanged for mode 101.
REQ-017 A write SHALL occur at the clock edge when we is in {001..101}, wa != 0 and rst = 0.
REQ-018 Reads SHALL be combinational.
REQ-019 rdN SHALL equal ext(we, wd) when a write is valid this cycle and wa == raN != 0 (write-through bypass); otherwise it SHALL equal the stored register.
REQ-020 The block SHALL hold a pending vector of NREG bits, with bit 0 constant 0.
REQ-021 pending[wa] SHALL clear at the edge of any valid write to wa.
REQ-022 pending[iss_rd] SHALL set at the edge when iss_v = 1, iss_rd != 0 and iss_stall = 0.
REQ-023 If an issue and a writeback target the same register in one cycle, set SHALL win and the bit SHALL remain 1.
REQ-024 An issue and a writeback to different registers in the same cycle SHALL both take effect.
REQ-025 busyN SHALL equal pending[raN] && !(valid write this cycle && wa == raN); busyN SHALL be 0 when raN == 0.
REQ-026 iss_stall SHALL equal iss_v && iss_rd != 0 && pending[iss_rd] && !(valid write this cycle && wa == iss_rd).
REQ-027 A stalled issue SHALL NOT modify pending; the requester holds iss_v and iss_rd until the stall drops.
REQ-028 Latency: write-to-read is 0 cycles through the bypass, or 1 cycle from storage; issue-to-busy is 1 cycle.
REQ-029 All outputs SHALL be functions of the current inputs and state only, with no registered outputs.

Reset
REQ-030 While rst = 1 at an edge, all registers SHALL be cleared to 0 and all pending bits to 0; writes and issues in that cycle SHALL be discarded.
REQ-031 After reset, rd1 = rd2 = 0 and busy1 = busy2 = iss_stall = 0 for any inputs, until the next write or issue.
REQ-032 Reset asserted mid-hazard SHALL clear outstanding pending bits, with no release handshake required.

Verification
REQ-033 Extension modes, default parameters: wd = 0x0000_8F80 written to r5 with we = 001, 010, 011, 100, 101 in turn -> r5 reads 0x80, 0xFFFF_FF80, 0x8F80, 0xFFFF_8F80, 0x0000_8F80.
REQ-034 Bypass and r0: same-cycle write r7 = 0x1234 with ra1 = 7 -> rd1 = 0x1234 in that cycle; write r0 = 0xFFFF_FFFF -> rd of r0 = 0 afterwards.
REQ-035 Scoreboard: issue r3; next cycle ra1 = 3 -> busy1 = 1; writeback r3 = 0xAA in a later cycle -> busy1 = 0 and rd1 = 0xAA in that same cycle.
REQ-036 Hazards: with r3 pending, issue r3 without writeback -> iss_stall = 1 and pending unchanged; issue r3 with a same-cycle writeback to r3 -> iss_stall = 0 and r3 stays pending.
REQ-037 Reset: set pending on r1, r2 and write r1 = 0x55, then pulse rst for one cycle -> rd = 0 and busy = 0 for both.
REQ-038 Parameter sweep: XLEN = 16, NREG = 8 -> mode 100 with wd = 0x8001 reads 0x8001; addresses 0..7 are all exercised.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file port bundle: write port, two read ports and the issue/scoreboard handshake.
// master drives addresses, data and issue requests; slave returns read data and hazard flags.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [2:0]      we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            iss_v;
    logic [AW-1:0]   iss_rd;
    logic            busy1;
    logic            busy2;
    logic            iss_stall;

    modport master (
        output we, wa, wd, ra1, ra2, iss_v, iss_rd,
        input  rd1, rd2, busy1, busy2, iss_stall
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, iss_v, iss_rd,
        output rd1, rd2, busy1, busy2, iss_stall
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with extending write port, write-through bypass and a pending-write
// scoreboard that flags RAW (busyN) and WAW (iss_stall) hazards combinationally.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_nxt;
    logic [XLEN-1:0] wr_val;
    logic            wr_mode_ok;
    logic            wr_valid;
    logic            hit1;
    logic            hit2;
    logic            hit_iss;
    logic            iss_set;

    always_comb begin
        wr_val = '0;
        case (bus.we)
            3'b001:  wr_val = XLEN'(bus.wd[7:0]);
            3'b010:  wr_val = XLEN'($signed(bus.wd[7:0]));
            3'b011:  wr_val = XLEN'(bus.wd[15:0]);
            3'b100:  wr_val = XLEN'($signed(bus.wd[15:0]));
            3'b101:  wr_val = bus.wd;
            default: wr_val = '0;
        endcase
    end

    // A write in a reset cycle is discarded, so it must not bypass or resolve hazards either.
    assign wr_mode_ok = (bus.we >= 3'b001) && (bus.we <= 3'b101);
    assign wr_valid   = wr_mode_ok && (bus.wa != '0) && !rst;

    assign hit1    = wr_valid && (bus.wa == bus.ra1);
    assign hit2    = wr_valid && (bus.wa == bus.ra2);
    assign hit_iss = wr_valid && (bus.wa == bus.iss_rd);

    assign bus.rd1 = hit1 ? wr_val : ((bus.ra1 == '0) ? '0 : regs[bus.ra1]);
    assign bus.rd2 = hit2 ? wr_val : ((bus.ra2 == '0) ? '0 : regs[bus.ra2]);

    assign bus.busy1 = (bus.ra1 != '0) && pending[bus.ra1] && !hit1;
    assign bus.busy2 = (bus.ra2 != '0) && pending[bus.ra2] && !hit2;

    // A writeback landing on the issue target this cycle resolves the WAW hazard.
    assign bus.iss_stall = bus.iss_v && (bus.iss_rd != '0) && pending[bus.iss_rd] && !hit_iss;
    assign iss_set       = bus.iss_v && (bus.iss_rd != '0) && !bus.iss_stall;

    // Clear first, then set, so a same-register issue and writeback leave the bit pending.
    always_comb begin
        pend_nxt = pending;
        if (wr_valid) begin
            pend_nxt[bus.wa] = 1'b0;
        end
        if (iss_set) begin
            pend_nxt[bus.iss_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[bus.wa] <= wr_val;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default (32x32) and reduced (16-bit x 8) instances, checked every
// cycle against an array/arithmetic model, plus directed literal expectations.
module tb_regfile_sb;

    logic clk;
    logic rst;

    regfile_sb_if #(.XLEN(32), .AW(5)) bus_a ();
    regfile_sb_if #(.XLEN(16), .AW(3)) bus_b ();

    regfile_sb #(.XLEN(32), .NREG(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    regfile_sb #(.XLEN(16), .NREG(8))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int     we;
        int     wa;
        longint wd;
        int     ra1;
        int     ra2;
        bit     iss_v;
        int     iss_rd;
    } in_t;

    longint m_reg  [2][32];
    bit     m_pend [2][32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint ext(int we, longint wd, int xl);
        longint v;
        longint full;
        full = longint'(1) << xl;
        case (we)
            1: v = wd % 256;
            2: begin
                v = wd % 256;
                if (v >= 128) v = v - 256 + full;
            end
            3: v = wd % 65536;
            4: begin
                v = wd % 65536;
                if (v >= 32768) v = v - 65536 + full;
            end
            5: v = wd % full;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic in_t get_in(int k);
        in_t i;
        if (k == 0) begin
            i.we = int'(bus_a.we);   i.wa = int'(bus_a.wa);   i.wd = longint'(bus_a.wd);
            i.ra1 = int'(bus_a.ra1); i.ra2 = int'(bus_a.ra2);
            i.iss_v = bus_a.iss_v;   i.iss_rd = int'(bus_a.iss_rd);
        end else begin
            i.we = int'(bus_b.we);   i.wa = int'(bus_b.wa);   i.wd = longint'(bus_b.wd);
            i.ra1 = int'(bus_b.ra1); i.ra2 = int'(bus_b.ra2);
            i.iss_v = bus_b.iss_v;   i.iss_rd = int'(bus_b.iss_rd);
        end
        return i;
    endfunction

    function automatic bit writes(in_t i);
        return !rst && i.we >= 1 && i.we <= 5 && i.wa != 0;
    endfunction

    function automatic bit stalls(int k, in_t i);
        return i.iss_v && i.iss_rd != 0 && m_pend[k][i.iss_rd] && !(writes(i) && i.wa == i.iss_rd);
    endfunction

    task automatic model_check(input int k, input in_t i, input logic [63:0] r1, input logic [63:0] r2,
                               input logic b1, input logic b2, input logic st);
        bit     wv;
        longint e;
        longint x1;
        longint x2;
        wv = writes(i);
        e  = ext(i.we, i.wd, (k == 0) ? 32 : 16);
        x1 = (wv && i.wa == i.ra1) ? e : ((i.ra1 == 0) ? 0 : m_reg[k][i.ra1]);
        x2 = (wv && i.wa == i.ra2) ? e : ((i.ra2 == 0) ? 0 : m_reg[k][i.ra2]);
        chk($sformatf("m%0d rd1 ra1=%0d", k, i.ra1), r1, x1);
        chk($sformatf("m%0d rd2 ra2=%0d", k, i.ra2), r2, x2);
        chk($sformatf("m%0d busy1 ra1=%0d", k, i.ra1), 64'(b1),
            64'(i.ra1 != 0 && m_pend[k][i.ra1] && !(wv && i.wa == i.ra1)));
        chk($sformatf("m%0d busy2 ra2=%0d", k, i.ra2), 64'(b2),
            64'(i.ra2 != 0 && m_pend[k][i.ra2] && !(wv && i.wa == i.ra2)));
        chk($sformatf("m%0d iss_stall rd=%0d", k, i.iss_rd), 64'(st), 64'(stalls(k, i)));
    endtask

    task automatic model_step(input int k, input in_t i);
        bit st;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[k][r]  = 0;
                m_pend[k][r] = 0;
            end
        end else begin
            st = stalls(k, i);
            if (writes(i)) begin
                m_reg[k][i.wa]  = ext(i.we, i.wd, (k == 0) ? 32 : 16);
                m_pend[k][i.wa] = 0;
            end
            if (i.iss_v && i.iss_rd != 0 && !st) m_pend[k][i.iss_rd] = 1;
        end
    endtask

    // Compare at negedge+2 against the model, then advance the model on the rising edge.
    initial begin
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                m_reg[k][r]  = 0;
                m_pend[k][r] = 0;
            end
        forever begin
            @(negedge clk);
            #2;
            model_check(0, get_in(0), 64'(bus_a.rd1), 64'(bus_a.rd2),
                        bus_a.busy1, bus_a.busy2, bus_a.iss_stall);
            model_check(1, get_in(1), 64'(bus_b.rd1), 64'(bus_b.rd2),
                        bus_b.busy1, bus_b.busy2, bus_b.iss_stall);
            @(posedge clk);
            model_step(0, get_in(0));
            model_step(1, get_in(1));
        end
    end

    task automatic va(input bit r, input int we, input int wa, input logic [31:0] wd,
                      input int ra1, input int ra2, input bit iv, input int ird);
        @(negedge clk);
        rst = r;
        bus_a.we = 3'(we);   bus_a.wa = 5'(wa);   bus_a.wd = wd;
        bus_a.ra1 = 5'(ra1); bus_a.ra2 = 5'(ra2);
        bus_a.iss_v = iv;    bus_a.iss_rd = 5'(ird);
        #3;
    endtask

    task automatic vb(input int we, input int wa, input logic [31:0] wd,
                      input int ra1, input int ra2, input bit iv, input int ird);
        @(negedge clk);
        bus_b.we = 3'(we);   bus_b.wa = 3'(wa);   bus_b.wd = wd[15:0];
        bus_b.ra1 = 3'(ra1); bus_b.ra2 = 3'(ra2);
        bus_b.iss_v = iv;    bus_b.iss_rd = 3'(ird);
        #3;
    endtask

    logic [31:0] exp_ext [1:5];

    initial begin
        exp_ext[1] = 32'h0000_0080;
        exp_ext[2] = 32'hFFFF_FF80;
        exp_ext[3] = 32'h0000_8F80;
        exp_ext[4] = 32'hFFFF_8F80;
        exp_ext[5] = 32'h0000_8F80;

        rst = 1'b1;
        bus_a.we = '0; bus_a.wa = '0; bus_a.wd = '0; bus_a.ra1 = '0; bus_a.ra2 = '0;
        bus_a.iss_v = 1'b0; bus_a.iss_rd = '0;
        bus_b.we = '0; bus_b.wa = '0; bus_b.wd = '0; bus_b.ra1 = '0; bus_b.ra2 = '0;
        bus_b.iss_v = 1'b0; bus_b.iss_rd = '0;

        va(1, 0, 0, 0, 0, 0, 0, 0);
        va(1, 5, 9, 32'hDEAD_BEEF, 9, 3, 1, 3);
        va(0, 0, 0, 0, 9, 3, 0, 0);
        chk("reset rd1", 64'(bus_a.rd1), 64'h0);
        chk("reset busy2", 64'(bus_a.busy2), 64'h0);

        for (int m = 1; m <= 5; m++) begin
            va(0, m, 5, 32'h0000_8F80, 0, 0, 0, 0);
            va(0, 0, 0, 0, 5, 0, 0, 0);
            chk($sformatf("ext mode %0d", m), 64'(bus_a.rd1), 64'(exp_ext[m]));
        end

        va(0, 5, 7, 32'h0000_1234, 7, 0, 0, 0);
        chk("bypass r7", 64'(bus_a.rd1), 64'h1234);
        va(0, 5, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("r0 write same cycle", 64'(bus_a.rd1), 64'h0);
        va(0, 0, 0, 0, 0, 7, 0, 0);
        chk("r0 after write", 64'(bus_a.rd1), 64'h0);
        chk("r7 stored", 64'(bus_a.rd2), 64'h1234);

        va(0, 0, 0, 0, 0, 0, 1, 3);
        chk("issue r3 no stall", 64'(bus_a.iss_stall), 64'h0);
        va(0, 0, 0, 0, 3, 0, 0, 0);
        chk("busy1 after issue", 64'(bus_a.busy1), 64'h1);
        va(0, 5, 3, 32'h0000_00AA, 3, 0, 0, 0);
        chk("busy1 at writeback", 64'(bus_a.busy1), 64'h0);
        chk("rd1 at writeback", 64'(bus_a.rd1), 64'hAA);

        va(0, 0, 0, 0, 3, 0, 1, 3);
        va(0, 0, 0, 0, 3, 0, 1, 3);
        chk("WAW stall", 64'(bus_a.iss_stall), 64'h1);
        va(0, 0, 0, 0, 3, 0, 1, 3);
        chk("stall held", 64'(bus_a.busy1), 64'h1);
        va(0, 5, 3, 32'h0000_0077, 3, 0, 1, 3);
        chk("stall resolved", 64'(bus_a.iss_stall), 64'h0);
        va(0, 0, 0, 0, 3, 0, 0, 0);
        chk("set wins", 64'(bus_a.busy1), 64'h1);
        chk("r3 value", 64'(bus_a.rd1), 64'h77);
        va(0, 5, 3, 32'h0000_0003, 3, 0, 0, 0);

        va(0, 0, 0, 0, 0, 0, 1, 6);
        va(0, 5, 6, 32'h0000_0009, 6, 4, 1, 4);
        va(0, 0, 0, 0, 6, 4, 0, 0);
        chk("diff-reg busy1", 64'(bus_a.busy1), 64'h0);
        chk("diff-reg busy2", 64'(bus_a.busy2), 64'h1);

        va(0, 5, 1, 32'h0000_0055, 0, 0, 0, 0);
        va(0, 0, 0, 0, 0, 0, 1, 1);
        va(0, 0, 0, 0, 1, 2, 1, 2);
        chk("pre-reset busy1", 64'(bus_a.busy1), 64'h1);
        chk("pre-reset rd1", 64'(bus_a.rd1), 64'h55);
        va(1, 0, 0, 0, 1, 2, 0, 0);
        va(0, 0, 0, 0, 1, 2, 0, 0);
        chk("post-reset rd1", 64'(bus_a.rd1), 64'h0);
        chk("post-reset busy1", 64'(bus_a.busy1), 64'h0);
        chk("post-reset busy2", 64'(bus_a.busy2), 64'h0);

        for (int a = 0; a < 8; a++) vb(5, a, 32'h1000 + 32'(a) * 32'h111, 0, 0, 0, 0);
        for (int a = 0; a < 8; a++) vb(0, 0, 0, a, 7 - a, 0, 0);
        vb(4, 2, 32'h0000_8001, 0, 0, 0, 0);
        vb(2, 3, 32'h0000_0080, 2, 3, 0, 0);
        chk("b mode4 0x8001", 64'(bus_b.rd1), 64'h8001);
        chk("b mode2 bypass", 64'(bus_b.rd2), 64'hFF80);
        vb(0, 0, 0, 0, 6, 1, 7);
        chk("b r6 stored", 64'(bus_b.rd2), 64'h1666);
        vb(0, 0, 0, 7, 0, 0, 0);
        chk("b busy r7", 64'(bus_b.busy1), 64'h1);
        vb(5, 7, 32'h0000_BEEF, 7, 0, 0, 0);
        chk("b wb r7", 64'(bus_b.rd1), 64'hBEEF);
        vb(0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
